sevenseg_scan_ctrl: RTL and testbench

- Parametrised multiplexed seven-segment display controller. Successor to the fixed 8-digit hex display path; sits between the processor's seven-segment write port and the board's segment and anode pins.
- Latches a display word on a write strobe and scans NUM_DIGITS digits with an internal refresh prescaler. No separate slow clock is needed.
- Adds a per-write decimal mode using a sequential binary-to-BCD converter, overflow indication, leading-zero blanking and per-digit decimal points.

---
 rtl/sevenseg_pkg.sv | 39 +++
 rtl/bin2bcd_seq.sv | 94 +++++++++
 rtl/sevenseg_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller: glyph font,
// special segment patterns and the converter state encoding.
package sevenseg_pkg;

    // Segment patterns are active-high, ordered {dp,g,f,e,d,c,b,a}.
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Standard hex font, active-high, dp bit left clear.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = 8'h3F;
            4'h1:    g = 8'h06;
            4'h2:    g = 8'h5B;
            4'h3:    g = 8'h4F;
            4'h4:    g = 8'h66;
            4'h5:    g = 8'h6D;
            4'h6:    g = 8'h7D;
            4'h7:    g = 8'h07;
            4'h8:    g = 8'h7F;
            4'h9:    g = 8'h6F;
            4'hA:    g = 8'h77;
            4'hB:    g = 8'h7C;
            4'hC:    g = 8'h39;
            4'hD:    g = 8'h5E;
            4'hE:    g = 8'h79;
            default: g = 8'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. One input bit is
// consumed per SHIFT cycle; DONE lasts one cycle with the result valid.
module bin2bcd_seq
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = $clog2(W);

    conv_state_t   state_q, state_d;
    logic [CW-1:0] count_q;
    logic [W-1:0]  bin_q;
    logic [W-1:0]  bcd_q;
    logic [W-1:0]  bcd_adj;
    logic          sticky_q;
    logic          last_shift;

    assign last_shift = (count_q == CW'(W - 1));
    assign bcd_out    = bcd_q;
    assign overflow   = sticky_q;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and status decode.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction on every BCD digit that is 5 or more.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Shift datapath: load on start, then shift {bcd, bin} left once per cycle.
    // A 1 leaving the top BCD digit means the value needs another digit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            bin_q    <= bin_in;
            bcd_q    <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            bcd_q    <= {bcd_adj[W-2:0], bin_q[W-1]};
            bin_q    <= {bin_q[W-2:0], 1'b0};
            sticky_q <= sticky_q | bcd_adj[W-1];
            count_q  <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment display controller: latches a display word,
// optionally converts it to decimal, and scans the digits with an internal
// refresh prescaler.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic                    wr_decimal,
    input  logic                    wr_blank_lz,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    output logic                    ready,
    output logic                    overflow,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   enables
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0]         presc_q;
    logic [IDX_W-1:0]      idx_q;
    logic [W-1:0]          buf_q;
    logic                  blank_q;
    logic [NUM_DIGITS-1:0] dp_q;
    logic                  ovf_q;
    logic                  hold_blank_q;
    logic [NUM_DIGITS-1:0] hold_dp_q;

    logic                  conv_start;
    logic                  conv_busy;
    logic                  conv_done;
    logic                  conv_ovf;
    logic [W-1:0]          conv_bcd;
    logic                  hex_write;

    logic [3:0]            digit_nib;
    logic                  upper_zero;
    logic [7:0]            seg_ah;
    logic [NUM_DIGITS-1:0] en_ah;

    assign ready      = !conv_busy;
    assign conv_start = wr_en && ready && wr_decimal;
    assign hex_write  = wr_en && ready && !wr_decimal;
    assign overflow   = ovf_q;

    bin2bcd_seq #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_bin2bcd (
        .clock    (clock),
        .reset    (reset),
        .start    (conv_start),
        .bin_in   (wr_data),
        .busy     (conv_busy),
        .done     (conv_done),
        .bcd_out  (conv_bcd),
        .overflow (conv_ovf)
    );

    // Refresh prescaler and digit scan index; free-running, never stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Display buffer: loaded directly by a hex write, or by the converter on
    // DONE using the flags held since the decimal write was accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_q        <= '0;
            blank_q      <= 1'b0;
            dp_q         <= '0;
            ovf_q        <= 1'b0;
            hold_blank_q <= 1'b0;
            hold_dp_q    <= '0;
        end else if (hex_write) begin
            buf_q   <= wr_data;
            blank_q <= wr_blank_lz;
            dp_q    <= wr_dp;
            ovf_q   <= 1'b0;
        end else if (conv_start) begin
            hold_blank_q <= wr_blank_lz;
            hold_dp_q    <= wr_dp;
        end else if (conv_done) begin
            buf_q   <= conv_bcd;
            blank_q <= hold_blank_q;
            dp_q    <= hold_dp_q;
            ovf_q   <= conv_ovf;
        end
    end

    // Glyph selection for the current digit, then output polarity.
    always_comb begin
        digit_nib  = buf_q[4*int'(idx_q) +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_q) && buf_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
        end

        if (ovf_q)                                   seg_ah = SEG_DASH;
        else if (blank_q && idx_q != '0 && upper_zero) seg_ah = SEG_BLANK;
        else                                         seg_ah = hex_glyph(digit_nib);
        seg_ah[7] = dp_q[idx_q];

        en_ah        = '0;
        en_ah[idx_q] = 1'b1;

        segments = (ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
        enables  = (ACTIVE_LOW != 0) ? ~en_ah  : en_ah;
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl (4 digits, divide-by-4 refresh,
// active-low). A behavioural model predicts every output each cycle; a set
// of literal expectations pins the model to hand-computed values.
module tb_sevenseg_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int W  = 4 * N;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_decimal = 1'b0;
    logic          wr_blank_lz = 1'b0;
    logic [N-1:0]  wr_dp = '0;
    logic          ready;
    logic          overflow;
    logic [7:0]    segments;
    logic [N-1:0]  enables;

    int n_checks = 0;
    int n_errors = 0;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .ACTIVE_LOW  (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_decimal  (wr_decimal),
        .wr_blank_lz (wr_blank_lz),
        .wr_dp       (wr_dp),
        .ready       (ready),
        .overflow    (overflow),
        .segments    (segments),
        .enables     (enables)
    );

    always #5 clock = ~clock;

    // Active-high hex font {dp,g,f,e,d,c,b,a}.
    logic [7:0] font [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Model state: cycles since reset, shown word, flags, and a countdown of
    // cycles until a pending decimal result lands.
    int          m_t;
    logic [15:0] m_buf;
    logic        m_blank;
    logic [3:0]  m_dp;
    logic        m_ovf;
    int          m_busy;
    int unsigned m_pend_val;
    logic        m_pend_blank;
    logic [3:0]  m_pend_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int d);
        logic [7:0] s;
        if (m_ovf)                                    s = 8'h40;
        else if (m_blank && d != 0 && (m_buf >> (4*d)) == 16'h0) s = 8'h00;
        else                                          s = font[m_buf[4*d +: 4]];
        s[7] = m_dp[d];
        return ~s;
    endfunction

    // Behavioural model, advanced on the same edges the DUT uses.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_t          <= 0;
            m_buf        <= '0;
            m_blank      <= 1'b0;
            m_dp         <= '0;
            m_ovf        <= 1'b0;
            m_busy       <= 0;
            m_pend_val   <= 0;
            m_pend_blank <= 1'b0;
            m_pend_dp    <= '0;
        end else begin
            m_t <= m_t + 1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_buf   <= to_bcd(m_pend_val);
                    m_ovf   <= (m_pend_val >= 10000);
                    m_blank <= m_pend_blank;
                    m_dp    <= m_pend_dp;
                end
            end else if (wr_en) begin
                if (wr_decimal) begin
                    m_busy       <= W + 1;
                    m_pend_val   <= int'(wr_data);
                    m_pend_blank <= wr_blank_lz;
                    m_pend_dp    <= wr_dp;
                end else begin
                    m_buf   <= wr_data;
                    m_blank <= wr_blank_lz;
                    m_dp    <= wr_dp;
                    m_ovf   <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        int         d;
        logic [3:0] e;
        forever begin
            @(negedge clock);
            #1;
            if (!reset) begin
                d = (m_t / RD) % N;
                e = 4'b0001 << d;
                e = ~e;
                check("cyc_enables",  32'(enables),  32'(e));
                check("cyc_segments", 32'(segments), 32'(exp_seg(d)));
                check("cyc_ready",    32'(ready),    32'(m_busy == 0));
                check("cyc_overflow", 32'(overflow), 32'(m_ovf));
            end
        end
    end

    task automatic do_write(input logic [15:0] data, input logic dec, input logic blank,
                            input logic [3:0] dp);
        @(negedge clock);
        wr_data     = data;
        wr_decimal  = dec;
        wr_blank_lz = blank;
        wr_dp       = dp;
        wr_en       = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic wait_digit(input int d);
        logic [3:0] e;
        int         n;
        e = 4'b0001 << d;
        e = ~e;
        n = 0;
        #1;
        while (enables !== e && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (enables !== e) check("wait_digit", 32'(enables), 32'(e));
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        #1;
        while (!ready && cnt < 100) begin
            cnt++;
            @(negedge clock);
            #1;
        end
    endtask

    // Directed stimulus with literal expectations.
    initial begin
        int         cnt;
        logic [3:0] scan_seq [4] = '{4'hD, 4'hB, 4'h7, 4'hE};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_enables",  32'(enables),  32'h0000_000E);
        check("rst_segments", 32'(segments), 32'h0000_00C0);
        check("rst_ready",    32'(ready),    32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            repeat (RD) @(negedge clock);
            #1;
            check("scan_step", 32'(enables), 32'(scan_seq[k]));
        end

        // Hex write 1A2F.
        do_write(16'h1A2F, 1'b0, 1'b0, 4'b0000);
        wait_digit(0); check("hex_d0", 32'(segments), 32'h8E);
        wait_digit(1); check("hex_d1", 32'(segments), 32'hA4);
        wait_digit(2); check("hex_d2", 32'(segments), 32'h88);
        wait_digit(3); check("hex_d3", 32'(segments), 32'hF9);

        // Decimal write 1234.
        do_write(16'd1234, 1'b1, 1'b0, 4'b0000);
        count_busy(cnt);
        check("dec_busy_cycles", 32'(cnt), 32'd17);
        wait_digit(0); check("dec_d0", 32'(segments), 32'h99);
        check("dec_ovf", 32'(overflow), 32'd0);
        wait_digit(3); check("dec_d3", 32'(segments), 32'hF9);

        // Decimal write 12345 overflows.
        do_write(16'd12345, 1'b1, 1'b0, 4'b0000);
        count_busy(cnt);
        check("ovf_busy_cycles", 32'(cnt), 32'd17);
        check("ovf_flag", 32'(overflow), 32'd1);
        wait_digit(0); check("ovf_d0", 32'(segments), 32'hBF);
        wait_digit(2); check("ovf_d2", 32'(segments), 32'hBF);
        do_write(16'h0000, 1'b0, 1'b0, 4'b0000);
        #1;
        check("ovf_clear", 32'(overflow), 32'd0);

        // Leading-zero blanking with a decimal point on digit 2.
        do_write(16'h0007, 1'b0, 1'b1, 4'b0100);
        wait_digit(0); check("lz_d0", 32'(segments), 32'hF8);
        wait_digit(1); check("lz_d1", 32'(segments), 32'hFF);
        wait_digit(2); check("lz_d2", 32'(segments), 32'h7F);
        wait_digit(3); check("lz_d3", 32'(segments), 32'hFF);

        // Decimal write, ignored second write, then reset mid-conversion.
        do_write(16'd4321, 1'b1, 1'b0, 4'b0000);
        repeat (4) @(negedge clock);
        wr_data    = 16'hBEEF;
        wr_decimal = 1'b0;
        wr_en      = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        #1;
        check("ignored_ready", 32'(ready), 32'd0);
        @(negedge clock);
        @(negedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        wait_digit(0); check("abort_d0", 32'(segments), 32'hC0);
        repeat (20) @(negedge clock);
        wait_digit(3); check("abort_no_load", 32'(segments), 32'hC0);
        check("abort_ovf", 32'(overflow), 32'd0);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
